// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole controller:
// FSM state encoding, LFSR seed/taps, default score register index
// and the LFSR step function.
package mole_pkg;

  typedef enum logic [0:0] {
    ST_GAP = 1'b0,
    ST_LIT = 1'b1
  } mole_state_t;

  // Polynomial x^16 + x^14 + x^13 + x^11 + 1; taps at bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Regfile index that receives injected hit counts
  localparam int SCORE_REG_DEFAULT = 30;

  // One Fibonacci step: feedback is the XOR of the tap bits, shifted in at bit 0
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    logic fb;
    fb = ^(cur & LFSR_TAPS);
    return {cur[14:0], fb};
  endfunction

endpackage

// File: rtl/mole_game_ctrl_btn.sv
// Per-channel button conditioning: 2-flop synchronizer, optional
// debounce filter and falling-edge (press) detector.
// Optional feature: define MOLE_DEBOUNCE_EN to enable the debounce filter.
module mole_btn_filter #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic press
);

  logic sync1_r;
  logic sync2_r;
  logic level_s;
  logic level_prev_r;

  // Bring the asynchronous active-low button into the clock domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= btn_n;
      sync2_r <= sync1_r;
    end
  end

`ifdef MOLE_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [CNT_W-1:0] cnt_r;
  logic             stable_r;

  // Accept a new level only after it has been seen for DEBOUNCE_CYCLES samples in a row
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_r <= 1'b1;
      cnt_r    <= CNT_W'(0);
    end else if (sync2_r == stable_r) begin
      cnt_r    <= CNT_W'(0);
    end else if (cnt_r == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      stable_r <= sync2_r;
      cnt_r    <= CNT_W'(0);
    end else begin
      cnt_r    <= cnt_r + CNT_W'(1);
    end
  end

  assign level_s = stable_r;
`else
  assign level_s = sync2_r;
`endif

  // Remember the previous filtered level for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_prev_r <= 1'b1;
    end else begin
      level_prev_r <= level_s;
    end
  end

  // A press is a released-to-pressed (1 -> 0) transition of the filtered level
  assign press = level_prev_r & ~level_s;

endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game controller. Lights one channel at a time for
// ON_CYCLES after an OFF_CYCLES dark gap, counts hits and misses, and
// opportunistically injects the pending hit count into regfile register
// SCORE_REG whenever the processor is not writing the regfile.
// Optional feature: define MOLE_DEBOUNCE_EN to debounce the buttons.
module mole_game_ctrl
  import mole_pkg::*;
#(
  parameter int NUM_CH          = 6,
  parameter int ON_CYCLES       = 100000000,
  parameter int OFF_CYCLES      = 50000000,
  parameter int PEND_W          = 3,
  parameter int SCORE_REG       = SCORE_REG_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] btn_n,
  input  logic              cpu_rwe,
  input  logic [4:0]        cpu_rd,
  input  logic [31:0]       cpu_wdata,
  output logic              rf_we,
  output logic [4:0]        rf_rd,
  output logic [31:0]       rf_wdata,
  input  logic [31:0]       score_in,
  output logic [NUM_CH-1:0] mole,
  output logic [NUM_CH-1:0] score_led,
  output logic              hit_pulse,
  output logic [15:0]       miss_cnt
);

  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [NUM_CH-1:0] ONE_CH   = NUM_CH'(1);
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [NUM_CH-1:0] press_s;
  logic [NUM_CH-1:0] hit_mask_s;
  logic [NUM_CH-1:0] miss_vec_s;
  logic [4:0]        miss_inc_s;
  logic [16:0]       miss_sum_s;
  logic              hit_s;
  logic              inject_s;
  logic [CH_W-1:0]   lfsr_ch_s;

  mole_state_t       state_r;
  logic [31:0]       timer_r;
  logic [15:0]       lfsr_r;
  logic [CH_W-1:0]   lit_ch_r;
  logic [NUM_CH-1:0] mole_r;
  logic              hit_pulse_r;
  logic [PEND_W-1:0] pending_r;
  logic              inj_prev_r;
  logic [15:0]       miss_cnt_r;
  logic [NUM_CH-1:0] score_led_r;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_btn
    mole_btn_filter #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
      .clk   (clk),
      .reset (reset),
      .btn_n (btn_n[g]),
      .press (press_s[g])
    );
  end

  assign lfsr_ch_s = CH_W'(lfsr_r % 16'(NUM_CH));

  // Classify this cycle's presses into a hit on the lit channel and misses elsewhere
  always_comb begin
    hit_s      = 1'b0;
    hit_mask_s = {NUM_CH{1'b0}};
    miss_inc_s = 5'd0;
    if (state_r == ST_LIT) begin
      hit_mask_s[lit_ch_r] = 1'b1;
      hit_s                = press_s[lit_ch_r];
    end else begin
      hit_mask_s = {NUM_CH{1'b0}};
      hit_s      = 1'b0;
    end
    miss_vec_s = press_s & ~hit_mask_s;
    for (int i = 0; i < NUM_CH; i++) begin
      miss_inc_s = miss_inc_s + 5'(miss_vec_s[i]);
    end
    miss_sum_s = {1'b0, miss_cnt_r} + {12'd0, miss_inc_s};
  end

  // Steal the regfile port only on idle cycles, never two cycles in a row
  assign inject_s = (pending_r != {PEND_W{1'b0}}) && !cpu_rwe && !inj_prev_r;

  // Regfile write mux: injected score update or processor pass-through
  always_comb begin
    rf_we    = cpu_rwe;
    rf_rd    = cpu_rd;
    rf_wdata = cpu_wdata;
    if (inject_s) begin
      rf_we    = 1'b1;
      rf_rd    = 5'(SCORE_REG);
      rf_wdata = 32'(pending_r);
    end else begin
      rf_we    = cpu_rwe;
      rf_rd    = cpu_rd;
      rf_wdata = cpu_wdata;
    end
  end

  // Game FSM: gap/lit timing, mole lamp and hit pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_GAP;
      timer_r     <= 32'd0;
      lit_ch_r    <= CH_W'(0);
      mole_r      <= {NUM_CH{1'b0}};
      hit_pulse_r <= 1'b0;
    end else begin
      hit_pulse_r <= 1'b0;
      case (state_r)
        ST_GAP: begin
          if (timer_r == 32'(OFF_CYCLES - 1)) begin
            state_r  <= ST_LIT;
            timer_r  <= 32'd0;
            lit_ch_r <= lfsr_ch_s;
            mole_r   <= ONE_CH << lfsr_ch_s;
          end else begin
            timer_r  <= timer_r + 32'd1;
          end
        end
        ST_LIT: begin
          if (hit_s) begin
            state_r     <= ST_GAP;
            timer_r     <= 32'd0;
            mole_r      <= {NUM_CH{1'b0}};
            hit_pulse_r <= 1'b1;
          end else if (timer_r == 32'(ON_CYCLES - 1)) begin
            state_r <= ST_GAP;
            timer_r <= 32'd0;
            mole_r  <= {NUM_CH{1'b0}};
          end else begin
            timer_r <= timer_r + 32'd1;
          end
        end
        default: begin
          state_r <= ST_GAP;
          timer_r <= 32'd0;
          mole_r  <= {NUM_CH{1'b0}};
        end
      endcase
    end
  end

  // Free-running LFSR used to pick the next lit channel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_r <= LFSR_SEED;
    end else begin
      lfsr_r <= lfsr_next(lfsr_r);
    end
  end

  // Pending-hit counter and injection history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_r  <= {PEND_W{1'b0}};
      inj_prev_r <= 1'b0;
    end else begin
      inj_prev_r <= inject_s;
      if (inject_s) begin
        pending_r <= hit_s ? PEND_ONE : {PEND_W{1'b0}};
      end else if (hit_s && (pending_r != PEND_MAX)) begin
        pending_r <= pending_r + PEND_ONE;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

  // Saturating miss counter, every non-hit press counts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      miss_cnt_r <= 16'd0;
    end else if (miss_sum_s[16]) begin
      miss_cnt_r <= 16'hFFFF;
    end else begin
      miss_cnt_r <= miss_sum_s[15:0];
    end
  end

  // Score display: one-hot of the regfile score modulo channel count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_led_r <= {NUM_CH{1'b0}};
    end else begin
      score_led_r <= ONE_CH << (score_in % 32'(NUM_CH));
    end
  end

  assign mole      = mole_r;
  assign hit_pulse = hit_pulse_r;
  assign miss_cnt  = miss_cnt_r;
  assign score_led = score_led_r;

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Directed self-checking bench for mole_game_ctrl (NUM_CH=4, ON=10, OFF=5).
module tb_mole_game_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  btn_n;
  logic        cpu_rwe;
  logic [4:0]  cpu_rd;
  logic [31:0] cpu_wdata;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [31:0] score_in;
  logic [3:0]  mole;
  logic [3:0]  score_led;
  logic        hit_pulse;
  logic [15:0] miss_cnt;

  int errors = 0;
  int checks = 0;

  mole_game_ctrl #(
    .NUM_CH(4), .ON_CYCLES(10), .OFF_CYCLES(5), .PEND_W(3),
    .SCORE_REG(30), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .reset(reset), .btn_n(btn_n),
    .cpu_rwe(cpu_rwe), .cpu_rd(cpu_rd), .cpu_wdata(cpu_wdata),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .score_in(score_in), .mole(mole), .score_led(score_led),
    .hit_pulse(hit_pulse), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // Reference LFSR: x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0
  function automatic logic [15:0] model_lfsr(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_lit(output int ch);
    int n;
    n  = 0;
    ch = 0;
    while (mole !== 4'b0000 && n < 60) begin tick(); n++; end
    while (mole === 4'b0000 && n < 60) begin tick(); n++; end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL wait_lit: timeout, mole=%b required nonzero", mole);
    end else begin
      for (int i = 0; i < 4; i++) if (mole[i]) ch = i;
    end
  endtask

  // Hold a button low long enough to pass the synchronizer, then release
  task automatic press(input int ch);
    btn_n[ch] = 1'b0;
    tick(); tick(); tick();
    btn_n[ch] = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; btn_n = 4'hF; cpu_rwe = 1'b0; cpu_rd = 5'd0;
    cpu_wdata = 32'd0; score_in = 32'd5;
    tick(); tick();
    checks++; if (mole !== 4'b0000) begin errors++; $display("FAIL reset_mole: got %b want 0000", mole); end
    checks++; if (hit_pulse !== 1'b0) begin errors++; $display("FAIL reset_hit: got %b want 0", hit_pulse); end
    checks++; if (miss_cnt !== 16'd0) begin errors++; $display("FAIL reset_miss: got %0d want 0", miss_cnt); end
    checks++; if (score_led !== 4'b0000) begin errors++; $display("FAIL reset_score_led: got %b want 0000", score_led); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
    reset = 1'b0;
  endtask

  // Free-running schedule from reset release: 5 dark, 10 lit, repeat
  task automatic test_timing();
    logic [15:0] m;
    logic [3:0]  exp_mole;
    int          exp_ch;
    m = 16'hACE1;
    exp_ch = 0;
    for (int k = 1; k <= 29; k++) begin
      if (k == 5 || k == 20) exp_ch = int'(m % 16'd4);
      m = model_lfsr(m);
      tick();
      exp_mole = ((k >= 5 && k <= 14) || (k >= 20 && k <= 29)) ? (4'b0001 << exp_ch) : 4'b0000;
      checks++;
      if (mole !== exp_mole) begin
        errors++;
        $display("FAIL timing_k%0d: mole=%b want %b", k, mole, exp_mole);
      end
    end
  endtask

  task automatic test_hit();
    int ch;
    wait_lit(ch);
    press(ch);
    checks++; if (hit_pulse !== 1'b1) begin errors++; $display("FAIL hit_pulse: got %b want 1", hit_pulse); end
    checks++; if (mole !== 4'b0000) begin errors++; $display("FAIL hit_mole_off: got %b want 0000", mole); end
    checks++;
    if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd30, 32'd1}) begin
      errors++;
      $display("FAIL hit_inject: we=%b rd=%0d wdata=%0d want 1/30/1", rf_we, rf_rd, rf_wdata);
    end
    tick();
    checks++; if (hit_pulse !== 1'b0) begin errors++; $display("FAIL hit_pulse_len: got %b want 0", hit_pulse); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL hit_single_inject: rf_we=%b want 0", rf_we); end
  endtask

  task automatic test_contention();
    int ch;
    wait_lit(ch);
    cpu_rwe = 1'b1; cpu_rd = 5'd5; cpu_wdata = 32'h0000_1234;
    press(ch);
    checks++; if (hit_pulse !== 1'b1) begin errors++; $display("FAIL cont_hit: got %b want 1", hit_pulse); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd5, 32'h0000_1234}) begin
        errors++;
        $display("FAIL cont_mirror_%0d: we=%b rd=%0d wdata=%h want 1/5/00001234", i, rf_we, rf_rd, rf_wdata);
      end
      if (i < 7) tick();
    end
    cpu_rwe = 1'b0;
    #1;
    checks++;
    if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd30, 32'd1}) begin
      errors++;
      $display("FAIL cont_inject: we=%b rd=%0d wdata=%0d want 1/30/1", rf_we, rf_rd, rf_wdata);
    end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL cont_after: rf_we=%b want 0", rf_we); end
  endtask

  task automatic test_saturation();
    int ch;
    int hits;
    hits = 0;
    cpu_rwe = 1'b1; cpu_rd = 5'd2; cpu_wdata = 32'hABCD_0000;
    for (int n = 0; n < 9; n++) begin
      wait_lit(ch);
      press(ch);
      if (hit_pulse === 1'b1) hits++;
    end
    checks++; if (hits !== 9) begin errors++; $display("FAIL sat_hits: got %0d want 9", hits); end
    cpu_rwe = 1'b0;
    #1;
    checks++;
    if ({rf_we, rf_rd, rf_wdata} !== {1'b1, 5'd30, 32'd7}) begin
      errors++;
      $display("FAIL sat_inject: we=%b rd=%0d wdata=%0d want 1/30/7", rf_we, rf_rd, rf_wdata);
    end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL sat_gap: rf_we=%b want 0", rf_we); end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL sat_once: rf_we=%b want 0", rf_we); end
  endtask

  task automatic test_miss();
    int ch;
    int wrong;
    int inj;
    inj = 0;
    do_reset();
    wait_lit(ch);
    wrong = (ch + 1) % 4;
    press(wrong);
    checks++; if (hit_pulse !== 1'b0) begin errors++; $display("FAIL miss_lit_hit: got %b want 0", hit_pulse); end
    checks++; if (miss_cnt !== 16'd1) begin errors++; $display("FAIL miss_lit_cnt: got %0d want 1", miss_cnt); end
    checks++; if (mole !== (4'b0001 << ch)) begin errors++; $display("FAIL miss_lit_mole: got %b want %b", mole, 4'b0001 << ch); end
    while (mole !== 4'b0000 && inj < 20) begin tick(); inj++; end
    inj = 0;
    btn_n[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin tick(); if (rf_we === 1'b1 || hit_pulse === 1'b1) inj++; end
    btn_n[0] = 1'b1;
    checks++; if (miss_cnt !== 16'd2) begin errors++; $display("FAIL miss_gap_cnt: got %0d want 2", miss_cnt); end
    checks++; if (inj !== 0) begin errors++; $display("FAIL miss_no_pending: %0d cycles with write/hit, want 0", inj); end
  endtask

  task automatic test_reset_mid_lit();
    int ch;
    int inj;
    inj = 0;
    cpu_rwe = 1'b1; cpu_rd = 5'd9; cpu_wdata = 32'h5555_AAAA;
    for (int n = 0; n < 3; n++) begin
      wait_lit(ch);
      press(ch);
    end
    wait_lit(ch);
    tick();
    #2 reset = 1'b1;
    #1;
    checks++; if (mole !== 4'b0000) begin errors++; $display("FAIL rst_mid_mole: got %b want 0000", mole); end
    checks++; if (miss_cnt !== 16'd0) begin errors++; $display("FAIL rst_mid_miss: got %0d want 0", miss_cnt); end
    checks++;
    if ({rf_we, rf_rd} !== {1'b1, 5'd9}) begin
      errors++;
      $display("FAIL rst_mid_pass: we=%b rd=%0d want 1/9", rf_we, rf_rd);
    end
    cpu_rwe = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rf_we === 1'b1) inj++;
    end
    checks++; if (inj !== 0) begin errors++; $display("FAIL rst_mid_no_inject: %0d writes want 0", inj); end
  endtask

  task automatic test_score_led();
    score_in = 32'd7;
    tick();
    checks++; if (score_led !== 4'b1000) begin errors++; $display("FAIL score_7: got %b want 1000", score_led); end
    score_in = 32'd13;
    tick();
    checks++; if (score_led !== 4'b0010) begin errors++; $display("FAIL score_13: got %b want 0010", score_led); end
    score_in = 32'd0;
    tick();
    checks++; if (score_led !== 4'b0001) begin errors++; $display("FAIL score_0: got %b want 0001", score_led); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_hit();
    test_contention();
    test_saturation();
    test_miss();
    test_reset_mid_lit();
    test_score_led();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
